// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, byte/half/word formatting, fault flags.
// Latency start->done: 1 cycle on faults, else 2 + ack wait; stalls on mem_ack up to TIMEOUT cycles.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        illegal,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_nxt;
    logic        store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [7:0]  tmo_cnt;

    logic        req_illegal;
    logic        req_misaligned;
    logic        tmo_hit;
    logic [31:0] lane;
    logic [31:0] load_fmt;

    always_comb begin
        req_illegal = store ? !(funct3 inside {3'b000, 3'b001, 3'b010})
                            : !(funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        req_misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                         ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    end

    assign tmo_hit = (tmo_cnt == 8'(TIMEOUT - 1));

    // Shift the addressed byte/halfword down to bit 0 before extension.
    assign lane = mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_fmt = 32'h0;
        if (!store_q) begin
            case (funct3_q)
                3'b000:  load_fmt = {{24{lane[7]}}, lane[7:0]};
                3'b001:  load_fmt = {{16{lane[15]}}, lane[15:0]};
                3'b010:  load_fmt = mem_rdata;
                3'b100:  load_fmt = {24'h0, lane[7:0]};
                3'b101:  load_fmt = {16'h0, lane[15:0]};
                default: load_fmt = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (req_illegal || req_misaligned) ? RESP : ACCESS;
            ACCESS:  if (mem_ack || tmo_hit) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            store_q    <= 1'b0;
            funct3_q   <= 3'b0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            tmo_cnt    <= 8'h0;
            rdata      <= 32'h0;
            misaligned <= 1'b0;
            illegal    <= 1'b0;
            bus_err    <= 1'b0;
        end else if (state == IDLE) begin
            tmo_cnt <= 8'h0;
            if (start) begin
                store_q    <= store;
                funct3_q   <= funct3;
                addr_q     <= addr;
                wdata_q    <= wdata;
                rdata      <= 32'h0;
                illegal    <= req_illegal;
                misaligned <= !req_illegal && req_misaligned;
                bus_err    <= 1'b0;
            end
        end else if (state == ACCESS) begin
            tmo_cnt <= tmo_cnt + 8'h1;
            // An ack in the last allowed cycle still wins over the timeout.
            if (mem_ack)      rdata   <= load_fmt;
            else if (tmo_hit) bus_err <= 1'b1;
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == RESP);
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wstrb = 4'b0000;
        mem_wdata = 32'h0;
        if (state == ACCESS) begin
            mem_req  = 1'b1;
            mem_we   = store_q;
            mem_addr = {addr_q[31:2], 2'b00};
            if (store_q) begin
                case (funct3_q[1:0])
                    2'b00: begin
                        mem_wstrb = 4'b0001 << addr_q[1:0];
                        mem_wdata = {4{wdata_q[7:0]}};
                    end
                    2'b01: begin
                        mem_wstrb = 4'b0011 << {addr_q[1], 1'b0};
                        mem_wdata = {2{wdata_q[15:0]}};
                    end
                    default: begin
                        mem_wstrb = 4'b1111;
                        mem_wdata = wdata_q;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT=4); expected results queued at issue, checked at done.
module tb_load_store_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst, start, store, mem_ack;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, mem_rdata;
    logic        busy, done, misaligned, illegal, bus_err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        ill;
        logic        berr;
        int          lat;
        int          reqs;
    } exp_t;

    exp_t sb[$];

    load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .store(store), .funct3(funct3),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .misaligned(misaligned), .illegal(illegal), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] rd, input logic m, input logic i,
                                input logic b, input int lat, input int reqs);
        exp_t e;
        e.rdata = rd; e.mis = m; e.ill = i; e.berr = b; e.lat = lat; e.reqs = reqs;
        return e;
    endfunction

    // ack_wait < 0 means never acknowledge.
    task automatic run(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input int ack_wait,
                       input logic [31:0] mrd, input exp_t e, input logic [31:0] e_addr,
                       input logic [3:0] e_strb, input logic [31:0] e_wd, input bit noise);
        int   cyc = 0;
        int   reqcnt = 0;
        bit   got_done = 0;
        exp_t item;
        @(negedge clk);
        start = 1'b1; store = st; funct3 = f3; addr = a; wdata = wd;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0; store = ~st; funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
        while (!got_done && cyc < 64) begin
            cyc++;
            if (done) begin
                got_done = 1;
                item = sb.pop_front();
                chk({tag, " latency"}, 32'(cyc), 32'(item.lat));
                chk({tag, " req_cycles"}, 32'(reqcnt), 32'(item.reqs));
                chk({tag, " rdata"}, rdata, item.rdata);
                chk({tag, " flags"}, {29'h0, misaligned, illegal, bus_err},
                    {29'h0, item.mis, item.ill, item.berr});
                if (noise) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk({tag, " done_1cyc"}, {31'h0, done}, 32'h0);
                chk({tag, " idle_after"}, {31'h0, busy}, 32'h0);
                chk({tag, " rdata_held"}, rdata, item.rdata);
            end else begin
                chk({tag, " busy"}, {31'h0, busy}, 32'h1);
                if (mem_req) begin
                    reqcnt++;
                    if (reqcnt == 1) begin
                        chk({tag, " mem_addr"}, mem_addr, e_addr);
                        chk({tag, " mem_wstrb"}, {28'h0, mem_wstrb}, {28'h0, e_strb});
                        chk({tag, " mem_we"}, {31'h0, mem_we}, {31'h0, st});
                        if (st) chk({tag, " mem_wdata"}, mem_wdata, e_wd);
                        if (noise) start = 1'b1;
                    end
                    if (ack_wait >= 0 && reqcnt == ack_wait + 1) begin
                        mem_ack = 1'b1;
                        mem_rdata = mrd;
                    end
                end
                @(negedge clk);
                mem_ack = 1'b0; start = 1'b0; mem_rdata = $urandom;
            end
        end
        if (!got_done) chk({tag, " done_timeout"}, 32'h0, 32'h1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; store = 1'b0; funct3 = 3'b0; addr = 32'h0;
        wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset ctrl", {25'h0, busy, done, mem_req, mem_we, misaligned, illegal, bus_err}, 32'h0);
        chk("reset mem_addr", mem_addr, 32'h0);
        chk("reset mem_wstrb", {28'h0, mem_wstrb}, 32'h0);
        chk("reset mem_wdata", mem_wdata, 32'h0);
        chk("reset rdata", rdata, 32'h0);

        run("LB", 0, 3'b000, 32'h103, 32'h0, 2, 32'h80FF1234,
            mk(32'hFFFFFF80, 0, 0, 0, 4, 3), 32'h100, 4'b0000, 32'h0, 1);
        run("LBU", 0, 3'b100, 32'h103, 32'h0, 2, 32'h80FF1234,
            mk(32'h00000080, 0, 0, 0, 4, 3), 32'h100, 4'b0000, 32'h0, 0);
        run("LH", 0, 3'b001, 32'h102, 32'h0, 0, 32'h80FF1234,
            mk(32'hFFFF80FF, 0, 0, 0, 2, 1), 32'h100, 4'b0000, 32'h0, 0);
        run("LHU", 0, 3'b101, 32'h102, 32'h0, 0, 32'h80FF1234,
            mk(32'h000080FF, 0, 0, 0, 2, 1), 32'h100, 4'b0000, 32'h0, 0);
        run("LW", 0, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF,
            mk(32'hDEADBEEF, 0, 0, 0, 3, 2), 32'h100, 4'b0000, 32'h0, 1);
        run("SH", 1, 3'b001, 32'h206, 32'h1234ABCD, 0, 32'h0,
            mk(32'h0, 0, 0, 0, 2, 1), 32'h204, 4'b1100, 32'hABCDABCD, 0);
        run("SB", 1, 3'b000, 32'h101, 32'h00000055, 1, 32'h0,
            mk(32'h0, 0, 0, 0, 3, 2), 32'h100, 4'b0010, 32'h55555555, 0);
        run("SW", 1, 3'b010, 32'h30C, 32'hCAFEF00D, 0, 32'h0,
            mk(32'h0, 0, 0, 0, 2, 1), 32'h30C, 4'b1111, 32'hCAFEF00D, 0);
        run("LW_misal", 0, 3'b010, 32'h302, 32'h0, 0, 32'h0,
            mk(32'h0, 1, 0, 0, 1, 0), 32'h0, 4'b0000, 32'h0, 1);
        run("ST_f3_011", 1, 3'b011, 32'h300, 32'h0, 0, 32'h0,
            mk(32'h0, 0, 1, 0, 1, 0), 32'h0, 4'b0000, 32'h0, 0);
        run("LD_f3_110_misal", 0, 3'b110, 32'h301, 32'h0, 0, 32'h0,
            mk(32'h0, 0, 1, 0, 1, 0), 32'h0, 4'b0000, 32'h0, 0);
        run("SH_misal", 1, 3'b001, 32'h201, 32'h0, 0, 32'h0,
            mk(32'h0, 1, 0, 0, 1, 0), 32'h0, 4'b0000, 32'h0, 0);
        run("timeout", 0, 3'b010, 32'h500, 32'h0, -1, 32'h0,
            mk(32'h0, 0, 0, 1, TMO + 1, TMO), 32'h500, 4'b0000, 32'h0, 0);
        run("ack_last_cycle", 0, 3'b010, 32'h504, 32'h0, TMO - 1, 32'h01234567,
            mk(32'h01234567, 0, 0, 0, TMO + 1, TMO), 32'h504, 4'b0000, 32'h0, 0);

        // Stray ack while idle must not disturb anything.
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_ack busy", {31'h0, busy}, 32'h0);
        chk("idle_ack done", {31'h0, done}, 32'h0);
        chk("idle_ack rdata", rdata, 32'h01234567);

        // Reset mid-access, with a simultaneous ack that reset must override.
        @(negedge clk);
        start = 1'b1; store = 1'b0; funct3 = 3'b010; addr = 32'h400;
        @(negedge clk);
        start = 1'b0;
        chk("rst_pre mem_req", {31'h0, mem_req}, 32'h1);
        rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h11111111;
        @(negedge clk);
        rst = 1'b0; mem_ack = 1'b0;
        chk("rst mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst busy", {31'h0, busy}, 32'h0);
        chk("rst done", {31'h0, done}, 32'h0);
        @(negedge clk);
        chk("rst no_done", {31'h0, done}, 32'h0);
        chk("rst rdata", rdata, 32'h0);

        run("LW_after_rst", 0, 3'b010, 32'h0, 32'h0, 0, 32'h13579BDF,
            mk(32'h13579BDF, 0, 0, 0, 2, 1), 32'h0, 4'b0000, 32'h0, 0);

        chk("scoreboard empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of cycles to wait for mem_ack before raising bus_err (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset; it is synchronous and active-high.
REQ-004 SHALL have port start, input, 1, a one-cycle request from the EX/MEM sequencer; it is sampled only in IDLE.
REQ-005 SHALL have port store, input, 1: 1 = store, 0 = load.
REQ-006 SHALL have port funct3, input, 3, the RV32I width/sign code.
REQ-007 SHALL have port addr, input, 32, the byte address.
REQ-008 SHALL have port wdata, input, 32, the store data taken from rs2.
REQ-009 SHALL have port busy, output, 1, high from the cycle after an accepted start until done.
REQ-010 SHALL have port done, output, 1, a single-cycle completion pulse.
REQ-011 SHALL have port rdata, output, 32, the formatted load result.
REQ-012 SHALL have port misaligned, output, 1, the alignment fault flag.
REQ-013 SHALL have port illegal, output, 1, the bad-funct3 flag.
REQ-014 SHALL have port bus_err, output, 1, the timeout flag.
REQ-015 SHALL have port mem_req, output, 1, the memory request; it is held until mem_ack.
REQ-016 SHALL have port mem_we, output, 1, the memory write enable.
REQ-017 SHALL have port mem_addr, output, 32, the word address; bits [1:0] are always 0.
REQ-018 SHALL have port mem_wstrb, output, 4, the byte lane enables.
REQ-019 SHALL have port mem_wdata, output, 32, the lane-replicated store data.
REQ-020 SHALL have ports mem_rdata, input, 32, and mem_ack, input, 1; mem_ack is a one-cycle acknowledge.

Function
REQ-021 SHALL use an FSM with three states: IDLE, ACCESS and RESP.
REQ-022 SHALL, in IDLE on start=1, register store, funct3, addr and wdata, then classify the request:
- illegal funct3 -> RESP with illegal=1.
- misaligned (halfword with addr[0]=1, word with addr[1:0]!=0) -> RESP with misaligned=1.
- otherwise -> ACCESS.
- A faulting request SHALL never assert mem_req.
REQ-023 SHALL treat loads with funct3 000/001/010/100/101 (LB/LH/LW/LBU/LHU) as legal; 011/110/111 are illegal.
REQ-024 SHALL treat stores with funct3 000/001/010 (SB/SH/SW) as legal; all others are illegal.
REQ-025 SHALL, in ACCESS, drive mem_req=1, mem_addr={addr[31:2],2'b00} and mem_we=store, all stable until the cycle mem_ack=1.
REQ-026 SHALL, on mem_ack in ACCESS, capture mem_rdata, drop mem_req the next cycle and go to RESP.
- Minimum latency from start to done is 3 cycles (start edge, ack cycle, done cycle).
REQ-027 SHALL drive mem_wstrb for stores as follows; mem_wstrb SHALL be 0000 for loads:
- SB: 0001<<addr[1:0]
- SH: 0011<<{addr[1],1'b0}
- SW: 1111
REQ-028 SHALL drive mem_wdata as follows:
- SB: {4{wdata[7:0]}}
- SH: {2{wdata[15:0]}}
- SW: wdata
REQ-029 SHALL format load data as follows:
- Select the byte or halfword lane using addr[1:0].
- LB/LH sign-extend from bit 7/15.
- LBU/LHU zero-extend.
- LW passes the word unchanged.
- Stores and faults return rdata=0.
REQ-030 SHALL count ACCESS cycles; if mem_ack has not arrived after TIMEOUT cycles, it SHALL drop mem_req and go to RESP with bus_err=1.
REQ-031 SHALL, in RESP, assert done=1 for exactly one cycle and then return to IDLE.
REQ-032 SHALL hold rdata and the three flags from RESP until the next accepted start, which clears them.
REQ-033 SHALL keep busy=1 in ACCESS and RESP and busy=0 in IDLE.
REQ-034 SHALL ignore start outside IDLE, including start in the same cycle as done.
REQ-035 SHALL ignore mem_ack outside ACCESS.
REQ-036 SHALL give mem_ack priority over timeout when mem_ack arrives in the final timeout cycle: the access completes normally with bus_err=0.
REQ-037 SHALL raise at most one flag per request, with priority illegal > misaligned > bus_err.

Reset
REQ-038 SHALL, on rst=1 at a clock edge, go to IDLE and clear the timeout counter.
REQ-039 SHALL, after reset, drive busy, done, mem_req, mem_we, misaligned, illegal and bus_err to 0, and mem_addr, mem_wstrb, mem_wdata and rdata to 0.
REQ-040 SHALL, on reset during ACCESS, drop mem_req in the cycle after rst is sampled, with no done pulse.
REQ-041 SHALL give rst priority over start and mem_ack in the same cycle.

Verification
REQ-042 SHALL pass a load test: LB at addr 0x103 with mem_rdata 0x80FF1234, ack after 2 cycles -> mem_addr 0x100, rdata 0xFFFFFF80, done one cycle; the same access as LBU -> 0x00000080.
REQ-043 SHALL pass a store test: SH at addr 0x206 with wdata 0x1234ABCD -> mem_addr 0x204, mem_wstrb 1100, mem_wdata 0xABCDABCD, mem_we 1.
REQ-044 SHALL pass a fault test: LW at 0x302 -> misaligned=1, done 1 cycle after start, mem_req never asserted; store with funct3 011 -> illegal=1.
REQ-045 SHALL pass a timeout test: TIMEOUT=4, mem_ack never asserted -> mem_req high for 4 cycles, then bus_err=1 and done.
REQ-046 SHALL pass a reset test: rst during ACCESS -> mem_req 0 next cycle, busy 0, no done; a following LW at 0x0 with ack after 0 wait cycles -> rdata equals mem_rdata.
REQ-047 SHALL pass an ignore test: start pulses while busy, and mem_ack while IDLE -> no state change and no extra done.
